// File: rtl/dram_pkg.sv
// DRAM controller shared widths, address word type and mapping modes.
// Field widths must sum with IGNORE_BITS to the width of word_t.
package dram_pkg;

   localparam int IGNORE_BITS     = 2;
   localparam int RANK_BITS       = 1;
   localparam int BANK_GROUP_BITS = 2;
   localparam int BANK_BITS       = 2;
   localparam int ROW_BITS        = 14;
   localparam int COLUMN_BITS     = 8;
   localparam int OFFSET_BITS     = 3;
   localparam int WORD_W          = 32;
   localparam int LEN_W           = 4;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      MAP_RBBRC = 2'd0,
      MAP_RRBBC = 2'd1,
      MAP_RARBC = 2'd2,
      MAP_RSVD  = 2'd3
   } map_mode_t;

   typedef struct packed {
      logic [RANK_BITS-1:0]       rank;
      logic [BANK_GROUP_BITS-1:0] bg;
      logic [BANK_BITS-1:0]       bank;
      logic [ROW_BITS-1:0]        row;
      logic [COLUMN_BITS-1:0]     col;
      logic [OFFSET_BITS-1:0]     offset;
   } coord_t;

endpackage

// File: rtl/dram_addr_rebuild_if.sv
// Coordinate-in / address-out handshake bundle for the reverse mapper.
// master is the producer/consumer side, slave is the rebuild block.
interface dram_addr_rebuild_if;
   import dram_pkg::*;

   logic                       in_valid;
   logic                       in_ready;
   logic [RANK_BITS-1:0]       in_rank;
   logic [BANK_GROUP_BITS-1:0] in_BG;
   logic [BANK_BITS-1:0]       in_bank;
   logic [ROW_BITS-1:0]        in_row;
   logic [COLUMN_BITS-1:0]     in_col;
   logic [OFFSET_BITS-1:0]     in_offset;
   logic [LEN_W-1:0]           in_len;
   map_mode_t                  in_mode;
   logic                       out_valid;
   logic                       out_ready;
   word_t                      out_address;
   logic                       out_last;
   logic                       out_wrap;
   logic                       out_mode_err;

   modport master (
      output in_valid, in_rank, in_BG, in_bank,
      output in_row, in_col, in_offset,
      output in_len, in_mode, out_ready,
      input  in_ready, out_valid, out_address,
      input  out_last, out_wrap, out_mode_err
   );

   modport slave (
      input  in_valid, in_rank, in_BG, in_bank,
      input  in_row, in_col, in_offset,
      input  in_len, in_mode, out_ready,
      output in_ready, out_valid, out_address,
      output out_last, out_wrap, out_mode_err
   );

endinterface

// File: rtl/dram_addr_compose.sv
// Combinational inverse of the forward address mapper.
// Reserved mode falls back to the mode 0 layout.
module dram_addr_compose
   import dram_pkg::*;
(
   input  coord_t    c,
   input  map_mode_t mode,
   output word_t     addr
);

   localparam int SUM = IGNORE_BITS + RANK_BITS
                      + BANK_GROUP_BITS + BANK_BITS
                      + ROW_BITS + COLUMN_BITS
                      + OFFSET_BITS;

   if (SUM != WORD_W) begin : g_width_chk
      $error("dram_pkg field widths do not fill word_t");
   end

   localparam logic [IGNORE_BITS-1:0] PAD = '0;

   always_comb begin
      addr = '0;
      unique case (1'b1)
         (mode == MAP_RRBBC):
            addr = {PAD, c.row, c.rank, c.bank,
                    c.bg, c.col, c.offset};
         (mode == MAP_RARBC):
            addr = {PAD, c.rank, c.row, c.bank,
                    c.bg, c.col, c.offset};
         default:
            addr = {PAD, c.row, c.bank, c.bg,
                    c.rank, c.col, c.offset};
      endcase
   end

endmodule

// File: rtl/dram_addr_rebuild.sv
// Reverse address mapper: one coordinate set in, one
// rebuilt address per beat out, column stepping per beat.
module dram_addr_rebuild
   import dram_pkg::*;
(
   input logic                CLK,
   input logic                nRST,
   dram_addr_rebuild_if.slave bus
);

   typedef enum logic {IDLE, BURST} state_t;

   localparam logic [COLUMN_BITS-1:0] COL_MAX = '1;
   localparam logic [LEN_W-1:0]       ONE     = 1;

   state_t           state;
   coord_t           q;
   map_mode_t        mode_q;
   logic [LEN_W-1:0] beat_cnt;

   logic      accept;
   logic      handoff;
   logic      advance;
   coord_t    nxt;
   map_mode_t nxt_mode;
   word_t     nxt_addr;

   assign bus.in_ready = (state == IDLE)
                      || (bus.out_valid
                          && bus.out_ready
                          && bus.out_last);

   assign accept  = bus.in_valid && bus.in_ready;
   assign handoff = bus.out_valid && bus.out_ready;
   assign advance = handoff && (beat_cnt != '0);

   // One compose instance serves both a fresh load and a column step.
   always_comb begin
      nxt      = q;
      nxt_mode = mode_q;
      nxt.col  = q.col + 1'b1;
      if (accept) begin
         nxt.rank   = bus.in_rank;
         nxt.bg     = bus.in_BG;
         nxt.bank   = bus.in_bank;
         nxt.row    = bus.in_row;
         nxt.col    = bus.in_col;
         nxt.offset = bus.in_offset;
         nxt_mode   = bus.in_mode;
      end
   end

   dram_addr_compose u_compose (
      .c    (nxt),
      .mode (nxt_mode),
      .addr (nxt_addr)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state            <= IDLE;
         q                <= '0;
         mode_q           <= MAP_RBBRC;
         beat_cnt         <= '0;
         bus.out_valid    <= 1'b0;
         bus.out_address  <= '0;
         bus.out_last     <= 1'b0;
         bus.out_wrap     <= 1'b0;
         bus.out_mode_err <= 1'b0;
      end else if (accept) begin
         state            <= BURST;
         q                <= nxt;
         mode_q           <= nxt_mode;
         beat_cnt         <= bus.in_len;
         bus.out_valid    <= 1'b1;
         bus.out_address  <= nxt_addr;
         bus.out_last     <= (bus.in_len == '0);
         bus.out_wrap     <= 1'b0;
         bus.out_mode_err <= (bus.in_mode == MAP_RSVD);
      end else if (advance) begin
         q               <= nxt;
         beat_cnt        <= beat_cnt - ONE;
         bus.out_address <= nxt_addr;
         bus.out_last    <= (beat_cnt == ONE);
         bus.out_wrap    <= (q.col == COL_MAX);
      end else if (handoff) begin
         state            <= IDLE;
         bus.out_valid    <= 1'b0;
         bus.out_address  <= '0;
         bus.out_last     <= 1'b0;
         bus.out_wrap     <= 1'b0;
         bus.out_mode_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dram_addr_rebuild.sv
// Directed and round-trip bench for dram_addr_rebuild.
// Expected addresses are hand-computed for the dram_pkg widths.
module tb_dram_addr_rebuild;
   import dram_pkg::*;

   logic CLK;
   logic nRST;
   int   n_cmp;
   int   n_bad;

   dram_addr_rebuild_if bus ();

   dram_addr_rebuild dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, need finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h need %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic offer(input int mode, input int rank,
                        input int bg, input int bank,
                        input int row, input int col,
                        input int off, input int len);
      bus.in_valid  = 1'b1;
      bus.in_mode   = map_mode_t'(mode);
      bus.in_rank   = RANK_BITS'(rank);
      bus.in_BG     = BANK_GROUP_BITS'(bg);
      bus.in_bank   = BANK_BITS'(bank);
      bus.in_row    = ROW_BITS'(row);
      bus.in_col    = COLUMN_BITS'(col);
      bus.in_offset = OFFSET_BITS'(off);
      bus.in_len    = LEN_W'(len);
   endtask

   task automatic beat(input string tag, input logic [31:0] a,
                       input logic lst, input logic wr,
                       input logic err);
      chk({tag, "_v"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_a"}, bus.out_address, a);
      chk({tag, "_l"}, 32'(bus.out_last), 32'(lst));
      chk({tag, "_w"}, 32'(bus.out_wrap), 32'(wr));
      chk({tag, "_e"}, 32'(bus.out_mode_err), 32'(err));
   endtask

   logic [31:0] t2 [4];
   logic [31:0] t4 [4];

   initial begin
      logic [31:0] a;
      int m;
      n_cmp = 0;
      n_bad = 0;
      t2[0] = 32'h1234_DFF5;
      t2[1] = 32'h1234_DFFD;
      t2[2] = 32'h1234_D805;
      t2[3] = 32'h1234_D80D;
      t4[0] = 32'h0ABC_6103;
      t4[1] = 32'h0ABC_610B;
      t4[2] = 32'h0ABC_6113;
      t4[3] = 32'h0ABC_611B;
      nRST = 1'b0;
      offer(0, 0, 0, 0, 0, 0, 0, 0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_addr", bus.out_address, 32'd0);
      chk("rst_last", 32'(bus.out_last), 32'd0);
      chk("rst_wrap", 32'(bus.out_wrap), 32'd0);
      chk("rst_err", 32'(bus.out_mode_err), 32'd0);
      tick();
      nRST = 1'b1;
      tick();

      // single beat, row only
      offer(0, 0, 0, 0, 16'h3FFF, 0, 0, 0);
      tick();
      bus.in_valid = 1'b0;
      beat("t1", 32'h3FFF_0000, 1'b1, 1'b0, 1'b0);
      chk("t1_rdy_held", 32'(bus.in_ready), 32'd0);
      bus.out_ready = 1'b1;
      #1;
      chk("t1_rdy_hand", 32'(bus.in_ready), 32'd1);
      tick();
      chk("t1_done_v", 32'(bus.out_valid), 32'd0);
      chk("t1_done_r", 32'(bus.in_ready), 32'd1);

      // column wrap in mode 1
      offer(1, 1, 3, 2, 16'h1234, 254, 5, 3);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         beat($sformatf("t2_%0d", i), t2[i],
              i == 3, i == 2, 1'b0);
         tick();
      end
      chk("t2_end_v", 32'(bus.out_valid), 32'd0);

      // back-to-back bursts
      offer(2, 1, 1, 1, 1, 16, 0, 1);
      tick();
      offer(0, 1, 0, 3, 2, 7, 1, 0);
      beat("t3_a0", 32'h2000_A880, 1'b0, 1'b0, 1'b0);
      chk("t3_rdy0", 32'(bus.in_ready), 32'd0);
      tick();
      beat("t3_a1", 32'h2000_A888, 1'b1, 1'b0, 1'b0);
      chk("t3_rdy1", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      beat("t3_b0", 32'h0002_C839, 1'b1, 1'b0, 1'b0);
      tick();
      chk("t3_end_v", 32'(bus.out_valid), 32'd0);

      // backpressure on beat 1
      offer(0, 0, 2, 1, 16'h0ABC, 32, 3, 3);
      tick();
      bus.in_valid = 1'b0;
      beat("t4_0", t4[0], 1'b0, 1'b0, 1'b0);
      tick();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         beat($sformatf("t4_hold%0d", i), t4[1],
              1'b0, 1'b0, 1'b0);
      end
      bus.out_ready = 1'b1;
      tick();
      beat("t4_2", t4[2], 1'b0, 1'b0, 1'b0);
      tick();
      beat("t4_3", t4[3], 1'b1, 1'b0, 1'b0);
      tick();
      chk("t4_end_v", 32'(bus.out_valid), 32'd0);

      // reserved mode, then reset mid-burst
      offer(3, 0, 2, 1, 16'h0ABC, 32, 3, 3);
      tick();
      bus.in_valid = 1'b0;
      beat("t5_0", t4[0], 1'b0, 1'b0, 1'b1);
      tick();
      beat("t5_1", t4[1], 1'b0, 1'b0, 1'b1);
      #1;
      nRST = 1'b0;
      #1;
      chk("t5_rst_v", 32'(bus.out_valid), 32'd0);
      chk("t5_rst_e", 32'(bus.out_mode_err), 32'd0);
      chk("t5_rst_a", bus.out_address, 32'd0);
      tick();
      nRST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t5_quiet%0d", i),
             32'(bus.out_valid), 32'd0);
      end

      // round trip through an independent forward slice
      for (int k = 0; k < 10000; k++) begin
         a = $urandom & 32'h3FFF_FFFF;
         m = k % 3;
         if (m == 0)
            offer(0, int'(a[11]), int'(a[13:12]),
                  int'(a[15:14]), int'(a[29:16]),
                  int'(a[10:3]), int'(a[2:0]), 0);
         else if (m == 1)
            offer(1, int'(a[15]), int'(a[12:11]),
                  int'(a[14:13]), int'(a[29:16]),
                  int'(a[10:3]), int'(a[2:0]), 0);
         else
            offer(2, int'(a[29]), int'(a[12:11]),
                  int'(a[14:13]), int'(a[28:15]),
                  int'(a[10:3]), int'(a[2:0]), 0);
         tick();
         bus.in_valid = 1'b0;
         chk($sformatf("rt%0d_m%0d", k, m),
             bus.out_address, a);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
